// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline types: control-sequencer states and the grouped enable/flush bundle
// that the datapath top fans out to the PC and the four pipeline buffer registers.
`timescale 1ns/1ps
package Pipe_Buf_Reg_PKG;

    typedef enum logic [2:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED,
        ERROR
    } ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_OFF = '0;

    function automatic logic load_use_hazard(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_mem_wait_timer.sv
// Counts consecutive wait cycles of one data-memory access; expired flags the
// wait cycle that would reach MEM_TIMEOUT without an acknowledge.
`timescale 1ns/1ps
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = count_en && (count_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational enables/flushes from
// the registered FSM state, plus halt drain, memory-wait timeout and stall statistics.
`timescale 1ns/1ps
module pipeline_ctrl
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   ex_memread,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_redirect,
    input  logic                   id_halt,
    input  logic                   wb_halt,
    input  logic                   mem_req,
    input  logic                   mem_ack,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   mem_wb_flush,
    output logic                   halted,
    output logic                   timeout_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    ctrl_state_e            state_q, state_d;
    logic                   origin_drain_q, origin_drain_d;
    logic                   halted_q, halted_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    pipe_ctrl_t ctrl;
    pipe_ctrl_t ctrl_out;
    logic       active;
    logic       mem_wait;
    logic       in_drain;
    logic       load_use;
    logic       stall_now;
    logic       expired;

    assign active   = (state_q == RUN) || (state_q == MEM_WAIT) || (state_q == DRAIN);
    assign mem_wait = active && mem_req && !mem_ack;
    // On the ack cycle of a wait, behave exactly as the state the wait interrupted.
    assign in_drain = (state_q == DRAIN) || ((state_q == MEM_WAIT) && origin_drain_q);
    assign load_use = load_use_hazard(ex_memread, ex_rd, id_rs1, id_rs2);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!mem_wait),
        .count_en(mem_wait),
        .expired (expired)
    );

    always_comb begin
        state_d        = state_q;
        origin_drain_d = origin_drain_q;
        halted_d       = halted_q;
        timeout_err_d  = timeout_err_q;
        stall_d        = stall_q;
        ctrl           = CTRL_RUN;
        stall_now      = 1'b0;

        if (!active) begin
            ctrl = CTRL_OFF;
        end else if (mem_wait) begin
            ctrl              = CTRL_OFF;
            ctrl.mem_wb_en    = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
            stall_now         = 1'b1;
            if (expired) begin
                state_d       = ERROR;
                timeout_err_d = 1'b1;
            end else begin
                if (state_q != MEM_WAIT) begin
                    origin_drain_d = (state_q == DRAIN);
                end
                state_d = MEM_WAIT;
            end
        end else if (in_drain) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = ex_redirect;
            state_d          = wb_halt ? HALTED : DRAIN;
            halted_d         = wb_halt;
        end else begin
            state_d = RUN;
            if (ex_redirect) begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end else if (load_use) begin
                ctrl.pc_en       = 1'b0;
                ctrl.if_id_en    = 1'b0;
                ctrl.id_ex_flush = 1'b1;
                stall_now        = 1'b1;
            end else if (id_halt) begin
                state_d = DRAIN;
            end
        end

        if (stall_now && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            origin_drain_q <= 1'b0;
            halted_q       <= 1'b0;
            timeout_err_q  <= 1'b0;
            stall_q        <= '0;
        end else begin
            state_q        <= state_d;
            origin_drain_q <= origin_drain_d;
            halted_q       <= halted_d;
            timeout_err_q  <= timeout_err_d;
            stall_q        <= stall_d;
        end
    end

    // Enables must drop the instant reset asserts, not at the next edge.
    assign ctrl_out = reset ? CTRL_OFF : ctrl;

    assign pc_en        = ctrl_out.pc_en;
    assign if_id_en     = ctrl_out.if_id_en;
    assign id_ex_en     = ctrl_out.id_ex_en;
    assign ex_mem_en    = ctrl_out.ex_mem_en;
    assign mem_wb_en    = ctrl_out.mem_wb_en;
    assign if_id_flush  = ctrl_out.if_id_flush;
    assign id_ex_flush  = ctrl_out.id_ex_flush;
    assign mem_wb_flush = ctrl_out.mem_wb_flush;
    assign halted       = halted_q;
    assign timeout_err  = timeout_err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario tasks with constant expectations, then randomized traffic checked against
// a cycle-level model of pipeline behaviour (drain/halt/error flags and wait counts).
`timescale 1ns/1ps
module tb_pipeline_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int STALL_CNT_W = 16;
    localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

    // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes, halted, timeout_err}
    localparam logic [9:0] V_OFF         = 10'b00000_000_00;
    localparam logic [9:0] V_IDLE        = 10'b11111_000_00;
    localparam logic [9:0] V_LU          = 10'b00111_010_00;
    localparam logic [9:0] V_REDIR       = 10'b11111_110_00;
    localparam logic [9:0] V_WAIT        = 10'b00001_001_00;
    localparam logic [9:0] V_DRAIN       = 10'b01111_100_00;
    localparam logic [9:0] V_DRAIN_REDIR = 10'b01111_110_00;
    localparam logic [9:0] V_HALTED      = 10'b00000_000_10;
    localparam logic [9:0] V_ERR         = 10'b00000_000_01;

    logic       clk, reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_memread, ex_redirect, id_halt, wb_halt, mem_req, mem_ack;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, halted, timeout_err;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic [9:0] obs;

    int tests_run;
    int tests_failed;
    int exp_stall;

    // Reference model state
    bit m_halted, m_err, m_drain;
    int m_waits, m_stalls;

    pipeline_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .id_halt     (id_halt),
        .wb_halt     (wb_halt),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .mem_wb_flush(mem_wb_flush),
        .halted      (halted),
        .timeout_err (timeout_err),
        .stall_cycles(stall_cycles)
    );

    assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, mem_wb_flush, halted, timeout_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
        ex_redirect = 1'b0; id_halt = 1'b0; wb_halt = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_stall = 0;
    endtask

    function automatic bit model_hazard();
        return ex_memread && (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    endfunction

    function automatic logic [9:0] model_exp();
        if (m_halted) return V_HALTED;
        if (m_err) return V_ERR;
        if (mem_req && !mem_ack) return V_WAIT;
        if (m_drain) return ex_redirect ? V_DRAIN_REDIR : V_DRAIN;
        if (ex_redirect) return V_REDIR;
        if (model_hazard()) return V_LU;
        return V_IDLE;
    endfunction

    task automatic model_step();
        if (m_halted || m_err) return;
        if (mem_req && !mem_ack) begin
            m_waits++;
            if (m_stalls < STALL_MAX) m_stalls++;
            if (m_waits >= MEM_TIMEOUT) m_err = 1'b1;
            return;
        end
        m_waits = 0;
        if (m_drain) begin
            if (wb_halt) begin
                m_halted = 1'b1;
                m_drain  = 1'b0;
            end
        end else if (!ex_redirect) begin
            if (model_hazard()) begin
                if (m_stalls < STALL_MAX) m_stalls++;
            end else if (id_halt) begin
                m_drain = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b0; m_err = 1'b0; m_drain = 1'b0; m_waits = 0; m_stalls = 0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (obs !== V_OFF) begin
            tests_failed++; $display("FAIL reset_outputs: got %b expected %b", obs, V_OFF);
        end
        tests_run++;
        if (stall_cycles !== '0) begin
            tests_failed++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
        end
        reset = 1'b0;
        exp_stall = 0;
        @(negedge clk);
        tests_run++;
        if (obs !== V_IDLE) begin
            tests_failed++; $display("FAIL post_reset_idle: got %b expected %b", obs, V_IDLE);
        end
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_load_use();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
        @(negedge clk);
        tests_run++;
        if (obs !== V_LU) begin
            tests_failed++; $display("FAIL load_use_rs1: got %b expected %b", obs, V_LU);
        end
        tick();
        exp_stall++;
        ex_memread = 1'b0;
        @(negedge clk);
        tests_run++;
        if (obs !== V_IDLE || stall_cycles !== STALL_CNT_W'(exp_stall)) begin
            tests_failed++;
            $display("FAIL load_use_one_cycle: got %b stall %0d expected %b stall %0d",
                     obs, stall_cycles, V_IDLE, exp_stall);
        end
        tick();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        @(negedge clk);
        tests_run++;
        if (obs !== V_IDLE) begin
            tests_failed++; $display("FAIL load_use_x0: got %b expected %b", obs, V_IDLE);
        end
        tick();
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
        @(negedge clk);
        tests_run++;
        if (obs !== V_LU) begin
            tests_failed++; $display("FAIL load_use_rs2: got %b expected %b", obs, V_LU);
        end
        tick();
        exp_stall++;
        set_idle();
        tests_run++;
        if (stall_cycles !== STALL_CNT_W'(exp_stall)) begin
            tests_failed++; $display("FAIL load_use_count: got %0d expected %0d", stall_cycles, exp_stall);
        end
        $display("[TB] test_load_use done");
    endtask

    task automatic test_redirect();
        ex_redirect = 1'b1; id_halt = 1'b1; ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
        @(negedge clk);
        tests_run++;
        if (obs !== V_REDIR) begin
            tests_failed++; $display("FAIL redirect_flush: got %b expected %b", obs, V_REDIR);
        end
        tick();
        set_idle();
        @(negedge clk);
        tests_run++;
        if (obs !== V_IDLE || stall_cycles !== STALL_CNT_W'(exp_stall)) begin
            tests_failed++;
            $display("FAIL redirect_stays_run: got %b stall %0d expected %b stall %0d",
                     obs, stall_cycles, V_IDLE, exp_stall);
        end
        tick();
        $display("[TB] test_redirect done");
    endtask

    task automatic test_mem_wait();
        mem_req = 1'b1; mem_ack = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== V_WAIT) begin
                tests_failed++; $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, obs, V_WAIT);
            end
            tick();
        end
        exp_stall += 3;
        mem_ack = 1'b1;
        @(negedge clk);
        tests_run++;
        if (obs !== V_REDIR) begin
            tests_failed++; $display("FAIL mem_ack_resume: got %b expected %b", obs, V_REDIR);
        end
        tick();
        ex_redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests_run++;
            if (obs !== V_IDLE) begin
                tests_failed++; $display("FAIL mem_zero_latency%0d: got %b expected %b", i, obs, V_IDLE);
            end
            tick();
        end
        tests_run++;
        if (stall_cycles !== STALL_CNT_W'(exp_stall)) begin
            tests_failed++; $display("FAIL mem_wait_count: got %0d expected %0d", stall_cycles, exp_stall);
        end
        set_idle();
        $display("[TB] test_mem_wait done");
    endtask

    task automatic test_timeout();
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== V_WAIT) begin
                tests_failed++; $display("FAIL timeout_wait%0d: got %b expected %b", i, obs, V_WAIT);
            end
            tick();
        end
        exp_stall += MEM_TIMEOUT;
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 2);
            @(negedge clk);
            tests_run++;
            if (obs !== V_ERR || stall_cycles !== STALL_CNT_W'(exp_stall)) begin
                tests_failed++;
                $display("FAIL timeout_sticky%0d: got %b stall %0d expected %b stall %0d",
                         i, obs, stall_cycles, V_ERR, exp_stall);
            end
            tick();
        end
        set_idle();
        do_reset();
        $display("[TB] test_timeout done");
    endtask

    task automatic test_halt();
        id_halt = 1'b1;
        @(negedge clk);
        tests_run++;
        if (obs !== V_IDLE) begin
            tests_failed++; $display("FAIL halt_detect: got %b expected %b", obs, V_IDLE);
        end
        tick();
        id_halt = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wb_halt = (i == 3);
            @(negedge clk);
            tests_run++;
            if (obs !== V_DRAIN) begin
                tests_failed++; $display("FAIL halt_drain%0d: got %b expected %b", i, obs, V_DRAIN);
            end
            tick();
        end
        wb_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_req = 1'b1; ex_redirect = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests_run++;
            if (obs !== V_HALTED || stall_cycles !== STALL_CNT_W'(exp_stall)) begin
                tests_failed++;
                $display("FAIL halted_hold%0d: got %b stall %0d expected %b stall %0d",
                         i, obs, stall_cycles, V_HALTED, exp_stall);
            end
            tick();
        end
        set_idle();
        do_reset();
        $display("[TB] test_halt done");
    endtask

    task automatic test_reset_in_drain();
        id_halt = 1'b1;
        tick();
        id_halt = 1'b0;
        @(negedge clk);
        tests_run++;
        if (obs !== V_DRAIN) begin
            tests_failed++; $display("FAIL rst_drain_enter: got %b expected %b", obs, V_DRAIN);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (obs !== V_OFF) begin
            tests_failed++; $display("FAIL rst_async_drop: got %b expected %b", obs, V_OFF);
        end
        tick();
        reset = 1'b0;
        exp_stall = 0;
        @(negedge clk);
        tests_run++;
        if (obs !== V_IDLE || stall_cycles !== '0) begin
            tests_failed++;
            $display("FAIL rst_drain_run: got %b stall %0d expected %b stall 0", obs, stall_cycles, V_IDLE);
        end
        tick();
        $display("[TB] test_reset_in_drain done");
    endtask

    task automatic test_random();
        int stuck;
        int bad;
        set_idle();
        do_reset();
        model_reset();
        stuck = 0;
        bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            ex_memread  = ($urandom % 100) < 40;
            ex_redirect = ($urandom % 100) < 10;
            id_halt     = ($urandom % 100) < 3;
            wb_halt     = ($urandom % 100) < 15;
            mem_req     = ($urandom % 100) < 35;
            mem_ack     = ($urandom % 100) < 65;
            @(negedge clk);
            tests_run++;
            if (obs !== model_exp() || stall_cycles !== STALL_CNT_W'(m_stalls)) begin
                tests_failed++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cyc%0d: got %b stall %0d expected %b stall %0d",
                             cyc, obs, stall_cycles, model_exp(), m_stalls);
            end
            model_step();
            tick();
            stuck = (m_halted || m_err) ? stuck + 1 : 0;
            if (stuck > 3 || ($urandom % 200) == 0) begin
                do_reset();
                model_reset();
                stuck = 0;
            end
        end
        set_idle();
        $display("[TB] test_random done");
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        exp_stall = 0;
        reset = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_reset_in_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enable and flush controls of the PC and the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB) from four sources: load-use hazards, taken branches/jumps resolved in EX, data-memory wait states and the halt marker. It owns the halt-drain FSM, a memory-wait timeout and a stall statistics counter.

## Interface
- MEM_TIMEOUT, 15: max consecutive wait cycles on one memory access before ERROR (≥1)
- STALL_CNT_W, 16: width of stall statistics counter

- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- id_rs1, id_rs2  in  5  source registers of instruction in IF/ID
- ex_memread  in  1  MemRead of ID/EX
- ex_rd  in  5  rd of ID/EX
- ex_redirect  in  1  branch taken or Jal resolved in EX this cycle
- id_halt  in  1  Halt_detect of IF/ID
- wb_halt  in  1  Halt_detect of MEM/WB
- mem_req  in  1  EX/MEM MemRead | MemWrite
- mem_ack  in  1  data memory completes access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load a bubble (all control bits 0) instead of data
- halted  out  1  pipeline stopped on halt
- timeout_err  out  1  sticky memory timeout
- stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED, ERROR.
- Per-cycle priority: ERROR/HALTED > memory wait > redirect > load-use > halt detect.
- Memory wait: mem_req & !mem_ack in RUN, MEM_WAIT or DRAIN.
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
  - mem_wb_en = 1, mem_wb_flush = 1, so the WB instruction does not repeat.
  - Enter MEM_WAIT from RUN, or stay in MEM_WAIT. Return to the origin state (RUN or DRAIN, held in a 1-bit register) on the cycle mem_ack = 1.
  - A redirect or load-use pending in the same cycle is held and acted on when the pipe advances.
- Redirect (ex_redirect): if_id_flush = id_ex_flush = 1, all enables 1. Squashes any halt or load-use in ID.
- Load-use: ex_memread & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - pc_en = if_id_en = 0.
  - id_ex_flush = 1.
  - Later stages keep their enables at 1.
- Halt detect: in RUN with id_halt and no higher-priority event → DRAIN.
  - From the next cycle: pc_en = 0 and if_id_flush = 1. Other stages advance.
  - wb_halt = 1 → HALTED.
- HALTED: all enables 0, flushes 0, halted = 1 until reset.
- ERROR: the wait counter reaching MEM_TIMEOUT without ack → ERROR. All enables 0, timeout_err = 1 until reset.
- Wait counter: cleared on entering MEM_WAIT and on ack. Increments each MEM_WAIT cycle.
- stall_cycles: +1 on every cycle with a load-use or memory-wait stall. Saturates at all-ones. Does not count in HALTED or ERROR.
- Idle outputs: all *_en = 1, flushes = 0.

## Timing
- Enables and flushes are combinational from the current state and inputs, with same-cycle effect. State, counters, halted and timeout_err are registered.
- Reset asserted: state = RUN, counters = 0, halted = 0, timeout_err = 0, all enables = 0, flushes = 0.
- First clock after reset release: enables = 1.
- mem_ack high in the same cycle as mem_req: zero-latency access, no stall.
- Load-use bubble: exactly 1 cycle per hazard.
- Redirect penalty: 2 squashed instructions.
- Halt: halted rises the cycle after wb_halt is sampled high in DRAIN.
- Reset mid-MEM_WAIT or mid-DRAIN: returns to RUN immediately, asynchronously.

## Structure
- Add the ctrl_state_e enum (RUN, MEM_WAIT, DRAIN, HALTED, ERROR) to the shared pipeline package Pipe_Buf_Reg_PKG.
- Add a packed struct pipe_ctrl_t there, grouping the enables and flushes for the datapath top.
- Natural sub-module: mem_wait_timer. It holds the wait counter and timeout compare, with inputs clk, reset, clear, count_en and output expired.

## Test plan
- Load-use: lw x5 in EX, add x6,x5,x1 in ID → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0→1. Same with ex_rd=0 → no stall.
- Taken branch: ex_redirect=1 while id_halt=1 and a load-use are present → if_id_flush=id_ex_flush=1, state stays RUN.
- Memory wait: mem_req=1 with mem_ack low for 3 cycles → 3 cycles of front-end enables=0 and mem_wb_flush=1, resume on ack, stall_cycles=3. mem_ack tied high → zero stalls.
- Timeout: MEM_TIMEOUT=4, mem_ack never asserts → timeout_err=1 after 4 wait cycles, all enables 0. Stays so until reset.
- Halt: id_halt pulse → DRAIN with pc_en=0. wb_halt three cycles later → halted=1 next cycle, all enables 0.
- Reset in DRAIN: assert reset asynchronously → enables drop immediately. After release, state RUN and halted=0.
